// File: rtl/wave_capture.sv
// Captures one trigger-aligned frame of audio samples into the back half of the
// double-buffered waveform RAM and flips the displayed half during display idle.
module wave_capture #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int COUNT_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    new_sample_ready,
  input  logic [SAMPLE_WIDTH-1:0] new_sample_in,
  input  logic                    wave_display_idle,
  output logic [COUNT_WIDTH:0]    write_address,
  output logic                    write_enable,
  output logic [7:0]              write_sample,
  output logic                    read_index,
  output logic [1:0]              debug_state
);

  typedef enum logic [1:0] {
    S_ARMED  = 2'd0,
    S_ACTIVE = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t                  state;
  logic [COUNT_WIDTH-1:0]  count;
  logic [SAMPLE_WIDTH-1:0] prev_sample;
  logic [7:0]              sample_conv;
  logic                    zero_cross;
  logic                    unused_bits;

  // Offset-binary: flip the sign bit of the top byte.
  assign sample_conv = {~new_sample_in[SAMPLE_WIDTH-1], new_sample_in[SAMPLE_WIDTH-2 -: 7]};
  assign zero_cross  = new_sample_ready && prev_sample[SAMPLE_WIDTH-1] &&
                       !new_sample_in[SAMPLE_WIDTH-1];
  assign unused_bits = ^{prev_sample[SAMPLE_WIDTH-2:0], new_sample_in[SAMPLE_WIDTH-9:0]};
  assign debug_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_ARMED;
      read_index    <= 1'b0;
      count         <= '0;
      prev_sample   <= '0;
      write_enable  <= 1'b0;
      write_address <= '0;
      write_sample  <= '0;
    end else begin
      write_enable <= 1'b0;
      if (new_sample_ready) prev_sample <= new_sample_in;
      case (state)
        S_ARMED: begin
          if (zero_cross) begin
            write_enable  <= 1'b1;
            write_address <= {~read_index, {COUNT_WIDTH{1'b0}}};
            write_sample  <= sample_conv;
            count         <= {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
            state         <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (new_sample_ready) begin
            write_enable  <= 1'b1;
            write_address <= {~read_index, count};
            write_sample  <= sample_conv;
            count         <= count + 1'b1;
            // Last slot: count wraps to zero and the frame waits for a swap.
            if (&count) state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wave_display_idle) begin
            read_index <= ~read_index;
            state      <= S_ARMED;
          end
        end
        default: state <= S_ARMED;
      endcase
    end
  end

endmodule

// File: tb/tb_wave_capture.sv
// Randomized bench for wave_capture: a frame-level reference model predicts every
// RAM write and the displayed half; a scoreboard queue checks them cycle by cycle.
module tb_wave_capture;

  logic        clk;
  logic        reset;
  logic        new_sample_ready;
  logic [15:0] new_sample_in;
  logic        wave_display_idle;
  logic [8:0]  write_address;
  logic        write_enable;
  logic [7:0]  write_sample;
  logic        read_index;
  logic [1:0]  debug_state;

  wave_capture #(.SAMPLE_WIDTH(16), .COUNT_WIDTH(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .new_sample_ready  (new_sample_ready),
    .new_sample_in     (new_sample_in),
    .wave_display_idle (wave_display_idle),
    .write_address     (write_address),
    .write_enable      (write_enable),
    .write_sample      (write_sample),
    .read_index        (read_index),
    .debug_state       (debug_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // scoreboard: each entry is {address[8:0], sample[7:0]}
  logic [16:0] exp_q[$];

  // reference model state
  bit                 shown;     // half wave_display reads
  int                 captured;  // samples written in the current frame (0 = not capturing)
  bit                 waiting;   // frame complete, waiting for display idle
  logic signed [15:0] prev_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_unsigned8(input logic signed [15:0] s);
    int u;
    u = int'(s) + 32768;
    return 8'(u / 256);
  endfunction

  task automatic model_reset();
    shown = 0;
    captured = 0;
    waiting = 0;
    prev_m = 0;
    exp_q.delete();
  endtask

  task automatic model_update(input logic rdy, input logic [15:0] s, input logic idle);
    logic signed [15:0] ss;
    int addr;
    ss = s;
    if (waiting) begin
      if (idle) begin
        shown = ~shown;
        waiting = 0;
      end
    end else if (rdy) begin
      if (captured > 0 || (prev_m < 0 && ss >= 0)) begin
        addr = (shown ? 0 : 256) + captured;
        exp_q.push_back({9'(addr), to_unsigned8(ss)});
        captured++;
        if (captured == 256) begin
          captured = 0;
          waiting = 1;
        end
      end
    end
    if (rdy) prev_m = ss;
  endtask

  task automatic compare();
    logic [16:0] e;
    logic [1:0]  st;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("write_enable", 32'(write_enable), 32'd1);
      check("write_address", 32'(write_address), 32'(e[16:8]));
      check("write_sample", 32'(write_sample), 32'(e[7:0]));
    end else begin
      check("write_enable", 32'(write_enable), 32'd0);
    end
    check("read_index", 32'(read_index), 32'(shown));
    st = waiting ? 2'd2 : (captured > 0 ? 2'd1 : 2'd0);
    check("state", 32'(debug_state), 32'(st));
  endtask

  // driver: one clock cycle with the given inputs
  task automatic step(input logic rdy, input logic [15:0] s, input logic idle);
    @(negedge clk);
    new_sample_ready  = rdy;
    new_sample_in     = s;
    wave_display_idle = idle;
    @(posedge clk);
    model_update(rdy, s, idle);
    #1;
    compare();
  endtask

  task automatic check_reset_values();
    check("rst_write_enable", 32'(write_enable), 32'd0);
    check("rst_read_index", 32'(read_index), 32'd0);
    check("rst_write_address", 32'(write_address), 32'd0);
    check("rst_write_sample", 32'(write_sample), 32'd0);
    check("rst_state", 32'(debug_state), 32'd0);
  endtask

  // asynchronous reset asserted between clock edges
  task automatic async_reset();
    @(negedge clk);
    new_sample_ready  = 1'b0;
    wave_display_idle = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_reset_values();
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_values();
  endtask

  task automatic wait_frame(input int n_samples, input int idle_at);
    for (int i = 0; i < n_samples; i++) begin
      repeat ($urandom_range(0, 1)) step(1'b0, 16'(($urandom)), 1'b0);
      step(1'b1, 16'($urandom), (i == idle_at));
    end
  endtask

  initial begin
    reset             = 1'b1;
    new_sample_ready  = 1'b0;
    new_sample_in     = '0;
    wave_display_idle = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    @(negedge clk);
    reset = 1'b0;

    // positive samples only: no trigger
    step(1'b1, 16'h0100, 1'b0);
    step(1'b1, 16'h0200, 1'b0);

    // arming crossing, then the rest of the frame with gaps between strobes
    step(1'b1, 16'hFF00, 1'b0);
    step(1'b1, 16'h0000, 1'b0);
    for (int i = 0; i < 255; i++) begin
      repeat ($urandom_range(0, 2)) step(1'b0, 16'h1234, 1'b0);
      step(1'b1, (i % 2 == 0) ? 16'h7FFF : 16'h8000, 1'b0);
    end

    // frame held: strobes (including a crossing) do not write
    step(1'b1, 16'h8000, 1'b0);
    step(1'b1, 16'h0100, 1'b0);
    step(1'b1, 16'hF000, 1'b0);
    repeat (10) step(1'b0, 16'h0000, 1'b0);
    // crossing and idle in the same cycle: swap wins, no trigger
    step(1'b1, 16'h0200, 1'b1);
    step(1'b1, 16'h0300, 1'b0);

    // second frame into the lower half, idle pulse mid-capture is ignored
    step(1'b1, 16'hF000, 1'b0);
    step(1'b1, 16'h0010, 1'b0);
    wait_frame(255, 49);
    repeat (3) step(1'b0, 16'h0000, 1'b0);
    step(1'b0, 16'h0000, 1'b1);

    // third frame aborted by reset after 100 writes
    step(1'b1, 16'h8001, 1'b0);
    step(1'b1, 16'h7001, 1'b0);
    wait_frame(99, -1);
    async_reset();
    repeat (5) step(1'b1, 16'($urandom_range(0, 16'h7FFF)), 1'b0);
    step(1'b1, 16'hC000, 1'b0);
    step(1'b1, 16'h0001, 1'b0);
    wait_frame(10, -1);
    async_reset();

    // fully random traffic
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 9) < 7), 16'($urandom), ($urandom_range(0, 19) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wave_capture.md
Name: wave_capture

Overview:
- Sits directly upstream of wave_display in the music player.
- Watches the codec-bound sample stream and arms on a positive-going zero crossing.
- Writes NUM_SAMPLES downscaled unsigned samples into the inactive half of the double-buffered waveform RAM.
- After the display reports idle, flips read_index so wave_display reads the fresh capture.

Parameters:
- SAMPLE_WIDTH, 16, width of the signed two's-complement input sample.
- COUNT_WIDTH, 8, log2 of samples per capture (NUM_SAMPLES = 256).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- new_sample_ready  input  1  single-cycle strobe; new_sample_in is valid this cycle.
- new_sample_in  input  SAMPLE_WIDTH  signed sample from the note/codec path.
- wave_display_idle  input  1  high while wave_display is not scanning the waveform region (vertical blank).
- write_address  output  COUNT_WIDTH+1  RAM write address = {~read_index, count}.
- write_enable  output  1  RAM write strobe, one cycle per captured sample.
- write_sample  output  8  unsigned 8-bit sample to RAM.
- read_index  output  1  half of the RAM that wave_display reads; capture always writes the other half.

Behaviour:
- Reset is asynchronous and active-high. Values while reset is asserted:
  - state = ARMED, read_index = 0, count = 0, prev_sample = 0.
  - write_enable = 0, write_address = 0, write_sample = 0.
- All outputs are registered. write_enable, write_address and write_sample change on the clock edge after the accepted new_sample_ready (latency 1).
- prev_sample loads new_sample_in on every new_sample_ready, in every state.
- Conversion: write_sample = {~s[SAMPLE_WIDTH-1], s[SAMPLE_WIDTH-2 -: 7]}, i.e. top 8 bits with the sign flipped (offset binary).
- Zero crossing: new_sample_ready && prev_sample MSB = 1 && new_sample_in MSB = 0. Input 0 counts as non-negative.
- State ARMED:
  - On a zero crossing: write the triggering sample at count 0, set count = 1, go to ACTIVE.
  - Otherwise write_enable stays 0.
- State ACTIVE:
  - Each new_sample_ready writes at the current count, then count increments.
  - The write with count = NUM_SAMPLES-1 is the last. Count wraps to 0 and the state goes to WAIT on that same edge.
  - No new zero-crossing check in ACTIVE.
- State WAIT:
  - Samples are not written; prev_sample still tracks.
  - On the first cycle with wave_display_idle = 1: toggle read_index, go to ARMED.
- wave_display_idle is ignored in ARMED and ACTIVE. A capture is never swapped in partially.
- write_enable is high for exactly one cycle per written sample and is 0 in every other cycle.
- write_address MSB always equals ~read_index at the time of the write. The capture never writes the half being displayed.
- new_sample_ready on consecutive cycles is legal in every state; each strobe is handled independently.
- Reset asserted mid-capture aborts the capture: state and outputs return to reset values (read_index = 0), and no further writes occur.
- Zero crossing and wave_display_idle arriving in the same cycle in WAIT: the swap wins and state goes to ARMED. That sample does not trigger, but it updates prev_sample.

Test Plan:
- Reset, then drive samples 0x0100, 0x0200 (no crossing) -> write_enable stays 0, state ARMED, read_index = 0.
- Arming crossing: drive 0xFF00 then 0x0000 -> the cycle after the 0x0000 strobe has write_enable = 1, write_address = 9'h100, write_sample = 8'h80.
- Full capture: drive 255 further samples (alternating 0x7FFF / 0x8000) after the crossing:
  - write_sample alternates 8'hFF / 8'h00.
  - Last write_address = 9'h1FF; state WAIT.
  - Further strobes produce no writes.
- Swap: in WAIT hold wave_display_idle = 0 for 10 cycles, then 1 -> read_index flips to 1 one cycle later. The next capture writes addresses 9'h000..9'h0FF.
- Mid-capture reset: assert reset after 100 writes -> write_enable = 0 and read_index = 0 immediately. After release, a new crossing restarts at write_address 9'h100.
- Idle during ACTIVE: pulse wave_display_idle at sample 50 -> read_index unchanged, capture completes all 256 writes.
